// File: rtl/udp_pkg.sv
// Shared UDP transmit definitions: hub FSM states, payload limit, default IPv4 id.
package udp_pkg;

   localparam int unsigned UDP_MAX_PAYLOAD = 1472;
   localparam logic [15:0] IPV4_ID_DEFAULT = 16'h0123;

   typedef enum logic [2:0] {
      HUB_IDLE,
      HUB_CHECK,
      HUB_START,
      HUB_WAIT_BUSY,
      HUB_STREAM,
      HUB_DONE
   } hub_state_e;

   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/udp_tx_hub_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping.
module rr_arbiter #(
   parameter int unsigned CH_N = 2,
   parameter int unsigned IW   = 1
) (
   input  logic [CH_N-1:0] req_i,
   input  logic [IW-1:0]   ptr_i,
   output logic [CH_N-1:0] gnt_o,
   output logic [IW-1:0]   idx_o,
   output logic            any_o
);

   int unsigned best;
   int unsigned best_j;

   // Rank each requester by its wrapped distance from the pointer; smallest wins.
   always_comb begin
      int unsigned d;
      best   = CH_N;
      best_j = 0;
      d      = 0;
      for (int unsigned j = 0; j < CH_N; j++) begin
         if (req_i[j]) begin
            d = (j >= 32'(ptr_i)) ? j - 32'(ptr_i) : j + CH_N - 32'(ptr_i);
            if (d < best) begin
               best   = d;
               best_j = j;
            end
         end
      end
   end

   always_comb begin
      any_o = (best < CH_N);
      idx_o = IW'(best_j);
      gnt_o = '0;
      for (int unsigned j = 0; j < CH_N; j++) begin
         gnt_o[j] = any_o && (best_j == j);
      end
   end

endmodule

// File: rtl/udp_tx_hub.sv
// Multi-channel UDP transmit front end: per-packet round-robin into one mac.
// Optional UDP_TX_HUB_STATS_EN adds per-channel sent/error counters.
module udp_tx_hub
   import udp_pkg::*;
#(
   parameter int unsigned CH_N         = 2,
   parameter int unsigned LEN_W        = 16,
   parameter int unsigned MAX_LEN      = UDP_MAX_PAYLOAD,
   parameter logic [15:0] IPV4_ID_INIT = IPV4_ID_DEFAULT,
   parameter int unsigned START_TMO    = 1023
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  I_mac_init_ready,
   input  logic [CH_N-1:0]       I_ch_req,
   input  logic [CH_N*LEN_W-1:0] I_ch_len,
   input  logic [CH_N*8-1:0]     I_ch_data,
   output logic [CH_N-1:0]       O_ch_grant,
   output logic [CH_N-1:0]       O_ch_rd,
   output logic [CH_N-1:0]       O_ch_err,
   output logic                  O_udp_tx_en,
   output logic [7:0]            O_udp_data,
   output logic [LEN_W-1:0]      O_udp_data_len,
   output logic [15:0]           O_ipv4_sign,
   input  logic                  I_udp_busy,
   input  logic                  I_udp_isLoadData,
   input  logic                  I_1Byte_pass,
`ifdef UDP_TX_HUB_STATS_EN
   output logic                  O_busy,
   output logic [CH_N*16-1:0]    O_stat_sent,
   output logic [CH_N*16-1:0]    O_stat_err
`else
   output logic                  O_busy
`endif
);

   localparam int unsigned IW = (CH_N > 1) ? $clog2(CH_N) : 1;
   localparam int unsigned TW = (START_TMO > 1) ? $clog2(START_TMO) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(START_TMO - 1);

   hub_state_e       state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [CH_N-1:0]  oh_q, oh_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [IW-1:0]    ptr_q, ptr_d;
   logic [CH_N-1:0]  grant_q, grant_d;
   logic [CH_N-1:0]  err_q, err_d;
   logic             txen_q, txen_d;
   logic [LEN_W-1:0] dlen_q, dlen_d;
   logic [15:0]      id_q, id_d;
   logic [TW-1:0]    tmo_q, tmo_d;
   logic             busy_q;

   logic [CH_N-1:0]  arb_gnt;
   logic [IW-1:0]    arb_idx;
   logic             arb_any;
   logic [LEN_W-1:0] sel_len;
   logic             len_bad;

   rr_arbiter #(
      .CH_N (CH_N),
      .IW   (IW)
   ) u_arb (
      .req_i (I_ch_req),
      .ptr_i (ptr_q),
      .gnt_o (arb_gnt),
      .idx_o (arb_idx),
      .any_o (arb_any)
   );

   always_comb begin
      sel_len = '0;
      for (int unsigned c = 0; c < CH_N; c++) begin
         if (arb_gnt[c]) sel_len = sel_len | I_ch_len[c*LEN_W +: LEN_W];
      end
   end

   assign len_bad = (len_q == '0) || (32'(len_q) > MAX_LEN);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      oh_d    = oh_q;
      len_d   = len_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      err_d   = '0;
      txen_d  = 1'b0;
      dlen_d  = dlen_q;
      id_d    = id_q;
      tmo_d   = tmo_q;
      unique case (state_q)
         HUB_IDLE: begin
            if (I_mac_init_ready && arb_any) begin
               idx_d   = arb_idx;
               oh_d    = arb_gnt;
               len_d   = sel_len;
               state_d = HUB_CHECK;
            end
         end
         HUB_CHECK: begin
            if (len_bad) begin
               err_d   = oh_q;
               ptr_d   = IW'(rr_next(32'(idx_q), CH_N));
               state_d = HUB_IDLE;
            end else begin
               grant_d = oh_q;
               dlen_d  = len_q;
               state_d = HUB_START;
            end
         end
         HUB_START: begin
            txen_d  = 1'b1;
            tmo_d   = '0;
            state_d = HUB_WAIT_BUSY;
         end
         HUB_WAIT_BUSY: begin
            if (I_udp_busy) begin
               state_d = HUB_STREAM;
            end else if (tmo_q == TMO_LAST) begin
               err_d   = oh_q;
               grant_d = '0;
               state_d = HUB_IDLE;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         HUB_STREAM: begin
            // End of packet is the registered falling edge of mac busy.
            if (busy_q && !I_udp_busy) state_d = HUB_DONE;
         end
         HUB_DONE: begin
            id_d    = id_q + 16'd1;
            grant_d = '0;
            ptr_d   = IW'(rr_next(32'(idx_q), CH_N));
            state_d = HUB_IDLE;
         end
         default: state_d = HUB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= HUB_IDLE;
         idx_q   <= '0;
         oh_q    <= '0;
         len_q   <= '0;
         ptr_q   <= '0;
         grant_q <= '0;
         err_q   <= '0;
         txen_q  <= 1'b0;
         dlen_q  <= '0;
         id_q    <= IPV4_ID_INIT;
         tmo_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         oh_q    <= oh_d;
         len_q   <= len_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         err_q   <= err_d;
         txen_q  <= txen_d;
         dlen_q  <= dlen_d;
         id_q    <= id_d;
         tmo_q   <= tmo_d;
         busy_q  <= I_udp_busy;
      end
   end

   always_comb begin
      O_udp_data = '0;
      for (int unsigned c = 0; c < CH_N; c++) begin
         if (grant_q[c]) O_udp_data = O_udp_data | I_ch_data[c*8 +: 8];
      end
   end

   assign O_ch_grant     = grant_q;
   assign O_ch_err       = err_q;
   assign O_udp_tx_en    = txen_q;
   assign O_udp_data_len = dlen_q;
   assign O_ipv4_sign    = id_q;
   assign O_busy         = (state_q != HUB_IDLE);
   assign O_ch_rd        = (state_q == HUB_STREAM && I_1Byte_pass && I_udp_isLoadData) ? oh_q : '0;

`ifdef UDP_TX_HUB_STATS_EN
   logic [15:0] sent_q [CH_N];
   logic [15:0] errc_q [CH_N];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned c = 0; c < CH_N; c++) begin
            sent_q[c] <= '0;
            errc_q[c] <= '0;
         end
      end else begin
         for (int unsigned c = 0; c < CH_N; c++) begin
            if (state_q == HUB_DONE && oh_q[c] && sent_q[c] != '1) sent_q[c] <= sent_q[c] + 16'd1;
            if (err_d[c] && errc_q[c] != '1) errc_q[c] <= errc_q[c] + 16'd1;
         end
      end
   end

   always_comb begin
      O_stat_sent = '0;
      O_stat_err  = '0;
      for (int unsigned c = 0; c < CH_N; c++) begin
         O_stat_sent[c*16 +: 16] = sent_q[c];
         O_stat_err[c*16 +: 16]  = errc_q[c];
      end
   end
`endif

endmodule

// File: tb/tb_udp_tx_hub.sv
// Directed bench for udp_tx_hub: two-channel main instance plus a single-channel id-wrap instance.
module tb_udp_tx_hub;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, init_ready, busy, isload, pass;
   logic [1:0]  req;
   logic [15:0] len0, len1;
   logic [7:0]  dbyte [2];
   logic [1:0]  grant, rd, err;
   logic        tx_en, hub_busy;
   logic [7:0]  udata;
   logic [15:0] dlen, id;

   logic        w_req, w_busy;
   logic [15:0] w_len;
   logic        w_grant, w_rd, w_err, w_txen, w_hbusy;
   logic [7:0]  w_udata;
   logic [15:0] w_dlen, w_id;

   int          total  = 0;
   int          passed = 0;
   logic [15:0] exp_id;
   int          k;
   logic        seen;

   udp_tx_hub #(
      .CH_N         (2),
      .LEN_W        (16),
      .MAX_LEN      (1472),
      .IPV4_ID_INIT (16'h0123),
      .START_TMO    (1023)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .I_mac_init_ready (init_ready),
      .I_ch_req         (req),
      .I_ch_len         ({len1, len0}),
      .I_ch_data        ({dbyte[1], dbyte[0]}),
      .O_ch_grant       (grant),
      .O_ch_rd          (rd),
      .O_ch_err         (err),
      .O_udp_tx_en      (tx_en),
      .O_udp_data       (udata),
      .O_udp_data_len   (dlen),
      .O_ipv4_sign      (id),
      .I_udp_busy       (busy),
      .I_udp_isLoadData (isload),
      .I_1Byte_pass     (pass),
      .O_busy           (hub_busy)
   );

   udp_tx_hub #(
      .CH_N         (1),
      .IPV4_ID_INIT (16'hFFFF)
   ) dut_wrap (
      .clk              (clk),
      .rst              (rst),
      .I_mac_init_ready (1'b1),
      .I_ch_req         (w_req),
      .I_ch_len         (w_len),
      .I_ch_data        (8'h5A),
      .O_ch_grant       (w_grant),
      .O_ch_rd          (w_rd),
      .O_ch_err         (w_err),
      .O_udp_tx_en      (w_txen),
      .O_udp_data       (w_udata),
      .O_udp_data_len   (w_dlen),
      .O_ipv4_sign      (w_id),
      .I_udp_busy       (w_busy),
      .I_udp_isLoadData (1'b0),
      .I_1Byte_pass     (1'b0),
      .O_busy           (w_hbusy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Mac model: busy 5 cycles after tx_en, n byte passes every other cycle, then busy falls.
   task automatic mac_serve(input int ch, input int n, input bit keep_req, input logic [15:0] exp_len);
      int w;
      w = 0;
      while (!tx_en && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk("tx_en_seen", tx_en, 1);
      chk("grant_at_start", grant, 32'(1) << ch);
      chk("data_len", dlen, exp_len);
      chk("id_at_start", id, exp_id);
      if (!keep_req) req[ch] = 1'b0;
      @(negedge clk);
      chk("tx_en_one_cycle", tx_en, 0);
      repeat (4) @(negedge clk);
      busy = 1'b1;
      for (int b = 0; b < n; b++) begin
         @(negedge clk);
         pass   = 1'b1;
         isload = 1'b1;
         #1;
         chk("rd_strobe", rd, 32'(1) << ch);
         chk("udp_data", udata, dbyte[ch]);
         @(negedge clk);
         pass   = 1'b0;
         isload = 1'b0;
         dbyte[ch] = dbyte[ch] + 8'd1;
      end
      @(negedge clk);
      busy = 1'b0;
      @(negedge clk);
      chk("grant_held_in_done", grant, 32'(1) << ch);
      chk("id_before_inc", id, exp_id);
      @(negedge clk);
      exp_id = exp_id + 16'd1;
      chk("grant_dropped", grant, 0);
      chk("id_incremented", id, exp_id);
      chk("idle_after_done", hub_busy, 0);
   endtask

   task automatic err_case(input logic [15:0] l);
      @(negedge clk);
      len1   = l;
      req[1] = 1'b1;
      @(negedge clk);
      chk("err_not_yet", err, 0);
      @(negedge clk);
      chk("err_pulse", err, 2'b10);
      chk("err_no_grant", grant, 0);
      chk("err_no_txen", tx_en, 0);
      req[1] = 1'b0;
      @(negedge clk);
      chk("err_one_cycle", err, 0);
      chk("err_no_txen2", tx_en, 0);
      chk("err_idle", hub_busy, 0);
   endtask

   initial begin
      #1ms;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      rst = 1'b1; init_ready = 1'b0; busy = 1'b0; isload = 1'b0; pass = 1'b0;
      req = 2'b00; len0 = '0; len1 = '0; dbyte[0] = 8'h10; dbyte[1] = 8'hA0;
      w_req = 1'b0; w_len = '0; w_busy = 1'b0;
      exp_id = 16'h0123;

      repeat (3) @(negedge clk);
      chk("rst_grant", grant, 0);
      chk("rst_rd", rd, 0);
      chk("rst_err", err, 0);
      chk("rst_txen", tx_en, 0);
      chk("rst_dlen", dlen, 0);
      chk("rst_id", id, 16'h0123);
      chk("rst_busy", hub_busy, 0);
      chk("rst_wrap_id", w_id, 16'hFFFF);
      rst = 1'b0;

      // single 16-byte packet on ch0
      @(negedge clk);
      init_ready = 1'b1; len0 = 16'd16; req[0] = 1'b1;
      @(negedge clk);
      chk("t1_check_no_grant", grant, 0);
      chk("t1_busy", hub_busy, 1);
      @(negedge clk);
      chk("t1_grant_before_txen", grant, 2'b01);
      chk("t1_txen_low", tx_en, 0);
      @(negedge clk);
      chk("t1_txen_3cyc", tx_en, 1);
      mac_serve(0, 16, 0, 16'd16);

      // length rejects on ch1 (also moves rr_ptr back to 0)
      err_case(16'd0);
      err_case(16'd1473);
      chk("err_id_unchanged", id, exp_id);

      // contended round robin 0,1,0,1 (ch1 at the MAX_LEN boundary)
      @(negedge clk);
      len0 = 16'd4; len1 = 16'd1472; req = 2'b11;
      mac_serve(0, 2, 1, 16'd4);
      mac_serve(1, 3, 1, 16'd1472);
      mac_serve(0, 2, 0, 16'd4);
      mac_serve(1, 3, 0, 16'd1472);

      // start timeout
      @(negedge clk);
      len0 = 16'd10; req[0] = 1'b1;
      k = 0;
      while (!tx_en && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("tmo_txen", tx_en, 1);
      req[0] = 1'b0;
      k = 0;
      while (err == 2'b00 && k < 1100) begin
         @(negedge clk);
         k++;
      end
      chk("tmo_cycles", k, 1023);
      chk("tmo_err", err, 2'b01);
      chk("tmo_grant_drop", grant, 0);
      @(negedge clk);
      chk("tmo_err_pulse", err, 0);
      chk("tmo_idle", hub_busy, 0);
      chk("tmo_id_unchanged", id, exp_id);

      // init_ready gating
      @(negedge clk);
      init_ready = 1'b0; len1 = 16'd5; req[1] = 1'b1;
      seen = 1'b0;
      repeat (100) begin
         @(negedge clk);
         if (grant != 2'b00 || tx_en) seen = 1'b1;
      end
      chk("init_no_grant", seen, 0);
      chk("init_idle", hub_busy, 0);
      init_ready = 1'b1;
      @(negedge clk);
      chk("init_txen_c1", tx_en, 0);
      @(negedge clk);
      chk("init_txen_c2", tx_en, 0);
      chk("init_grant", grant, 2'b10);
      @(negedge clk);
      chk("init_txen_c3", tx_en, 1);
      init_ready = 1'b0;
      mac_serve(1, 2, 0, 16'd5);
      init_ready = 1'b1;

      // id wrap on the single-channel instance
      @(negedge clk);
      w_len = 16'd20; w_req = 1'b1;
      k = 0;
      while (!w_txen && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("wrap_txen", w_txen, 1);
      chk("wrap_grant", w_grant, 1);
      chk("wrap_dlen", w_dlen, 16'd20);
      w_req = 1'b0;
      @(negedge clk);
      w_busy = 1'b1;
      repeat (3) @(negedge clk);
      w_busy = 1'b0;
      @(negedge clk);
      chk("wrap_id_before", w_id, 16'hFFFF);
      @(negedge clk);
      chk("wrap_id_after", w_id, 16'h0000);
      chk("wrap_grant_drop", w_grant, 0);

      // reset in the middle of STREAM
      @(negedge clk);
      len0 = 16'd8; req[0] = 1'b1;
      k = 0;
      while (!tx_en && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("mrst_txen", tx_en, 1);
      req[0] = 1'b0;
      @(negedge clk);
      busy = 1'b1;
      @(negedge clk);
      pass = 1'b1; isload = 1'b1;
      #1;
      chk("mrst_streaming", rd, 2'b01);
      rst = 1'b1; busy = 1'b0;
      @(negedge clk);
      chk("mrst_grant", grant, 0);
      chk("mrst_rd", rd, 0);
      chk("mrst_err", err, 0);
      chk("mrst_txen", tx_en, 0);
      chk("mrst_dlen", dlen, 0);
      chk("mrst_id", id, 16'h0123);
      chk("mrst_busy", hub_busy, 0);
      rst = 1'b0; pass = 1'b0; isload = 1'b0;
      repeat (2) @(negedge clk);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/udp_tx_hub.md
# udp_tx_hub

Multi-channel UDP transmit front end between N packet sources (camera line packer, command responder, …) and the single `mac` UDP transmitter. Round-robin arbitration per packet, gating on PHY/SMI init completion, length checking, a start-timeout watchdog and a synchronous IPv4 identification counter that advances once per completed packet. Sits in `mac_top` between the application sources and `mac`; all logic runs in the RMII 50 MHz domain.

## Interface
- `CH_N`, 2, number of source channels (1..8)
- `LEN_W`, 16, payload length width
- `MAX_LEN`, 1472, largest accepted payload in bytes
- `IPV4_ID_INIT`, 16'h0123, identification value after reset
- `START_TMO`, 1023, cycles allowed from `O_udp_tx_en` to `I_udp_busy` high
- `clk`  in  1  50 MHz RMII clock; one clock, all ports synchronous to it
- `rst`  in  1  reset, synchronous and active-high
- `I_mac_init_ready`  in  1  SMI/PHY init complete; no grant while low
- `I_ch_req`  in  CH_N  per-channel packet request, held until grant or error
- `I_ch_len`  in  CH_N*LEN_W  per-channel payload length, stable while req high
- `I_ch_data`  in  CH_N*8  per-channel first-word-fall-through byte
- `O_ch_grant`  out  CH_N  one-hot, high from grant to packet end
- `O_ch_rd`  out  CH_N  byte-consumed strobe to granted channel
- `O_ch_err`  out  CH_N  one-cycle pulse: length reject or start timeout
- `O_udp_tx_en`  out  1  start pulse to `mac`
- `O_udp_data`  out  8  byte to `mac` (combinational mux of granted channel)
- `O_udp_data_len`  out  LEN_W  latched payload length
- `O_ipv4_sign`  out  16  IPv4 identification for current packet
- `I_udp_busy`, `I_udp_isLoadData`, `I_1Byte_pass`  in  1 each  status from `mac`
- `O_busy`  out  1  hub not in IDLE

## Operation
- States: IDLE, CHECK, START, WAIT_BUSY, STREAM, DONE.
- IDLE: if `I_mac_init_ready` and any `I_ch_req`, pick first requester at or after round-robin pointer `rr_ptr` (wrapping CH_N-1→0); latch index and length; → CHECK.
- CHECK: length 0 or > `MAX_LEN` → pulse `O_ch_err[idx]`, `rr_ptr`=idx+1, → IDLE. Else assert `O_ch_grant[idx]`, → START.
- START: `O_udp_tx_en`=1 for exactly one cycle; clear timeout counter; → WAIT_BUSY.
- WAIT_BUSY: `I_udp_busy` high → STREAM; counter reaching `START_TMO` → err pulse, drop grant, → IDLE (id not incremented).
- STREAM: `O_ch_rd[idx]` = `I_1Byte_pass & I_udp_isLoadData`; source shows next byte the cycle after. `I_udp_busy` falling (registered compare) → DONE.
- DONE: `O_ipv4_sign` += 1 (16-bit wrap, 16'hFFFF→0000), drop grant, `rr_ptr`=idx+1, → IDLE.
- `I_mac_init_ready` low mid-packet does not abort; it only blocks new grants.
- Requests arriving during a packet wait; a channel re-requesting immediately loses to any other pending channel.
- Reset mid-packet: all state cleared next edge; `mac` is reset by same `rst`.

## Timing
- Reset values: `O_ch_grant`=0, `O_ch_rd`=0, `O_ch_err`=0, `O_udp_tx_en`=0, `O_udp_data_len`=0, `O_ipv4_sign`=`IPV4_ID_INIT`, `O_busy`=0, `rr_ptr`=0, state IDLE.
- Request to `O_udp_tx_en`: 3 cycles (IDLE→CHECK→START), grant visible 1 cycle before tx_en.
- Busy fall to grant drop and id increment: 2 cycles; next grant no earlier than 2 cycles after DONE.
- `O_udp_data_len` and `O_ipv4_sign` stable from START until DONE.
- Single-channel build (`CH_N`=1): `rr_ptr` is a constant 0.

## Configuration
- `UDP_TX_HUB_STATS_EN`: defined → per-channel 16-bit saturating sent-packet and error counters, exposed on `O_stat_sent` (CH_N*16) and `O_stat_err` (CH_N*16), cleared by `rst`. Undefined → ports and counters absent; behaviour otherwise identical.

## Structure
- Package `udp_pkg`: hub state enum, `UDP_MAX_PAYLOAD`=1472, `IPV4_ID_DEFAULT`, shared with `mac`.
- Sub-module `rr_arbiter` (CH_N requests, pointer in, one-hot grant and index out, combinational).

## Test plan
- CH_N=2, ch0 req len=16, mac model busy 5 cycles after tx_en for 16 byte passes → 16 `O_ch_rd[0]` pulses, `O_ipv4_sign` 0123→0124.
- ch0 and ch1 req together, repeated 4 packets → grants 0,1,0,1.
- ch1 len=0 then len=1473 → two `O_ch_err[1]` pulses, no `O_udp_tx_en`, id unchanged.
- mac busy never rises → err pulse exactly `START_TMO` cycles after WAIT_BUSY entry, return to IDLE.
- `I_mac_init_ready` low with req high for 100 cycles → no grant; rises → tx_en 3 cycles later.
- Start id 16'hFFFF, one packet → 16'h0000; assert `rst` mid-STREAM → all outputs at reset values next cycle.
